// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Brief    : Command encodings, FSM states, operand classification and default
//            parameters for alu_pipe. Honours ALU_MUL_EN for cmds 9/10.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DEF_WIDTH   = 8;
    localparam int c_DEF_TIMEOUT = 16;
    localparam int c_DEF_MUL_LAT = 3;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8,
        A_MUL_INC = 4'd9,
        A_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MUL  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OPC_TWO     = 2'd0,
        OPC_A       = 2'd1,
        OPC_B       = 2'd2,
        OPC_INVALID = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input logic mode, input logic [3:0] cmd);
        op_class_e cls;
        cls = OPC_INVALID;
        if (mode) begin
            case (arith_cmd_e'(cmd))
                A_INC_A, A_DEC_A:                        cls = OPC_A;
                A_INC_B, A_DEC_B:                        cls = OPC_B;
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: cls = OPC_TWO;
`ifdef ALU_MUL_EN
                A_MUL_INC, A_MUL_SHL:                    cls = OPC_TWO;
`endif
                default:                                 cls = OPC_INVALID;
            endcase
        end else begin
            case (logic_cmd_e'(cmd))
                L_NOT_A, L_SHR1_A, L_SHL1_A:             cls = OPC_A;
                L_NOT_B, L_SHR1_B, L_SHL1_B:             cls = OPC_B;
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
                L_ROL_A_B, L_ROR_A_B:                    cls = OPC_TWO;
                default:                                 cls = OPC_INVALID;
            endcase
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_pipe_if
// Brief     : Driver/monitor-facing command and result bus of alu_pipe.
// Revision  : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic               ce;
    logic               mode;
    logic [3:0]         cmd;
    logic [1:0]         inp_valid;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               cin;
    logic [2*WIDTH-1:0] res;
    logic               res_valid;
    logic               busy;
    logic               err;
    logic               oflow;
    logic               cout;
    logic               g;
    logic               l;
    logic               e;

    modport master (
        output ce, mode, cmd, inp_valid, opa, opb, cin,
        input  res, res_valid, busy, err, oflow, cout, g, l, e
    );

    modport slave (
        input  ce, mode, cmd, inp_valid, opa, opb, cin,
        output res, res_valid, busy, err, oflow, cout, g, l, e
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_pipe
// Brief    : Registered multiplier with LAT stages and a matching valid chain.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_pipe #(
    parameter int OP_W  = 9,
    parameter int OUT_W = 16,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic             i_valid,
    input  logic [OP_W-1:0]  i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_prod
);

    logic [LAT-1:0]   r_vld;
    logic [OUT_W-1:0] r_prod [LAT];

    // Product is formed at OUT_W so the truncation is implicit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) r_prod[i] <= '0;
        end else if (i_ce) begin
            r_vld     <= {r_vld[LAT-2:0], i_valid};
            r_prod[0] <= OUT_W'(i_a) * OUT_W'(i_b);
            for (int i = 1; i < LAT; i++) r_prod[i] <= r_prod[i-1];
        end
    end

    assign o_valid = r_vld[LAT-1];
    assign o_prod  = r_prod[LAT-1];

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Parametrised ALU with split operand arrival, timeout and optional
//            pipelined multiply (enabled by defining ALU_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int TIMEOUT = c_DEF_TIMEOUT,
    parameter int MUL_LAT = c_DEF_MUL_LAT
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);

    localparam int c_RW = 2 * WIDTH;
    localparam int c_SH = $clog2(WIDTH);
    localparam int c_CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH:0] c_ONE = {{WIDTH{1'b0}}, 1'b1};

    state_e            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_opa, r_opb;
    logic [3:0]        r_cmd;
    logic              r_mode, r_cin, r_have_a;

    logic [c_RW-1:0]   r_res;
    logic              r_res_valid, r_err, r_oflow, r_cout, r_g, r_l, r_e;

    logic              w_in_wait;
    logic [3:0]        w_cmd;
    logic              w_mode, w_cin;
    logic [WIDTH-1:0]  w_a, w_b;
    op_class_e         w_cls;
    logic              w_is_mul;

    logic [WIDTH:0]    w_xa, w_xb, w_xc, w_t;
    logic [WIDTH-1:0]  w_lv;
    logic [c_RW-1:0]   w_rot, w_res;
    logic [c_SH-1:0]   w_amt;
    logic              w_hi_b;
    logic              w_err, w_oflow, w_cout, w_g, w_l, w_e;

    logic              w_go, w_latch, w_fire, w_fail, w_mul_go, w_mul_done;
    logic              w_mul_vld;
    logic [c_RW-1:0]   w_mul_prod;

    // In WAIT the latched command and present operand take over from the bus
    assign w_in_wait = (r_state == WAIT);
    assign w_cmd     = w_in_wait ? r_cmd  : bus.cmd;
    assign w_mode    = w_in_wait ? r_mode : bus.mode;
    assign w_cin     = w_in_wait ? r_cin  : bus.cin;
    assign w_a       = (w_in_wait &&  r_have_a) ? r_opa : bus.opa;
    assign w_b       = (w_in_wait && !r_have_a) ? r_opb : bus.opb;
    assign w_cls     = op_class(w_mode, w_cmd);

    assign w_xa   = {1'b0, w_a};
    assign w_xb   = {1'b0, w_b};
    assign w_xc   = {{WIDTH{1'b0}}, w_cin};
    assign w_amt  = w_b[c_SH-1:0];
    assign w_hi_b = |(w_b >> c_SH);

    always_comb begin
        w_res   = '0;
        w_err   = 1'b0;
        w_oflow = 1'b0;
        w_cout  = 1'b0;
        w_g     = 1'b0;
        w_l     = 1'b0;
        w_e     = 1'b0;
        w_t     = '0;
        w_lv    = '0;
        w_rot   = '0;
        if (w_mode) begin
            case (arith_cmd_e'(w_cmd))
                A_ADD:     begin w_t = w_xa + w_xb;        w_cout  = w_t[WIDTH]; end
                A_SUB:     begin w_t = w_xa - w_xb;        w_oflow = w_t[WIDTH]; end
                A_ADD_CIN: begin w_t = w_xa + w_xb + w_xc; w_cout  = w_t[WIDTH]; end
                A_SUB_CIN: begin w_t = w_xa - w_xb - w_xc; w_oflow = w_t[WIDTH]; end
                A_INC_A:   begin w_t = w_xa + c_ONE;       w_cout  = w_t[WIDTH]; end
                A_DEC_A:   begin w_t = w_xa - c_ONE;       w_oflow = w_t[WIDTH]; end
                A_INC_B:   begin w_t = w_xb + c_ONE;       w_cout  = w_t[WIDTH]; end
                A_DEC_B:   begin w_t = w_xb - c_ONE;       w_oflow = w_t[WIDTH]; end
                A_CMP: begin
                    w_g = (w_a > w_b);
                    w_l = (w_a < w_b);
                    w_e = (w_a == w_b);
                end
                default:   w_err = 1'b1;
            endcase
            w_res = {{(WIDTH-1){1'b0}}, w_t};
        end else begin
            case (logic_cmd_e'(w_cmd))
                L_AND:     w_lv = w_a & w_b;
                L_NAND:    w_lv = ~(w_a & w_b);
                L_OR:      w_lv = w_a | w_b;
                L_NOR:     w_lv = ~(w_a | w_b);
                L_XOR:     w_lv = w_a ^ w_b;
                L_XNOR:    w_lv = ~(w_a ^ w_b);
                L_NOT_A:   w_lv = ~w_a;
                L_NOT_B:   w_lv = ~w_b;
                L_SHR1_A:  w_lv = w_a >> 1;
                L_SHL1_A:  w_lv = w_a << 1;
                L_SHR1_B:  w_lv = w_b >> 1;
                L_SHL1_B:  w_lv = w_b << 1;
                L_ROL_A_B: begin
                    w_rot = {w_a, w_a} << w_amt;
                    w_lv  = w_rot[c_RW-1:WIDTH];
                    w_err = w_hi_b;
                end
                L_ROR_A_B: begin
                    w_rot = {w_a, w_a} >> w_amt;
                    w_lv  = w_rot[WIDTH-1:0];
                    w_err = w_hi_b;
                end
                default:   w_err = 1'b1;
            endcase
            w_res = {{WIDTH{1'b0}}, w_lv};
        end
    end

`ifdef ALU_MUL_EN
    logic [WIDTH:0] w_mul_a, w_mul_b;

    assign w_is_mul = w_mode && ((w_cmd == A_MUL_INC) || (w_cmd == A_MUL_SHL));
    assign w_mul_a  = (w_cmd == A_MUL_INC) ? (w_xa + c_ONE) : {w_a, 1'b0};
    assign w_mul_b  = (w_cmd == A_MUL_INC) ? (w_xb + c_ONE) : w_xb;

    alu_mul_pipe #(
        .OP_W  (WIDTH + 1),
        .OUT_W (c_RW),
        .LAT   (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (bus.ce),
        .i_valid (w_mul_go),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_valid (w_mul_vld),
        .o_prod  (w_mul_prod)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_vld  = 1'b0;
    assign w_mul_prod = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go        = 1'b0;
        w_latch     = 1'b0;
        w_fire      = 1'b0;
        w_fail      = 1'b0;
        w_mul_go    = 1'b0;
        w_mul_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.inp_valid == 2'b00) begin
                    w_fail = 1'b1;
                end else begin
                    case (w_cls)
                        OPC_A:   if (bus.inp_valid[0]) w_fire = 1'b1; else w_fail = 1'b1;
                        OPC_B:   if (bus.inp_valid[1]) w_fire = 1'b1; else w_fail = 1'b1;
                        OPC_TWO: begin
                            if (bus.inp_valid == 2'b11) begin
                                w_go = 1'b1;
                            end else begin
                                w_latch     = 1'b1;
                                w_cnt_nxt   = '0;
                                w_state_nxt = WAIT;
                            end
                        end
                        default: w_fire = 1'b1;
                    endcase
                end
            end
            WAIT: begin
                if (r_have_a ? bus.inp_valid[1] : bus.inp_valid[0]) begin
                    w_go        = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CW'(TIMEOUT - 1)) begin
                    w_fail      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (w_mul_vld) begin
                    w_mul_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
        if (w_go) begin
            if (w_is_mul) begin
                w_mul_go    = 1'b1;
                w_state_nxt = MUL;
            end else begin
                w_fire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (bus.ce) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_cmd       <= '0;
            r_mode      <= 1'b0;
            r_cin       <= 1'b0;
            r_have_a    <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_oflow     <= 1'b0;
            r_cout      <= 1'b0;
            r_g         <= 1'b0;
            r_l         <= 1'b0;
            r_e         <= 1'b0;
        end else if (bus.ce) begin
            r_res_valid <= w_fire | w_fail | w_mul_done;
            if (w_latch) begin
                r_opa    <= bus.opa;
                r_opb    <= bus.opb;
                r_cmd    <= bus.cmd;
                r_mode   <= bus.mode;
                r_cin    <= bus.cin;
                r_have_a <= bus.inp_valid[0];
            end
            if (w_fire) begin
                r_res   <= w_res;
                r_err   <= w_err;
                r_oflow <= w_oflow;
                r_cout  <= w_cout;
                r_g     <= w_g;
                r_l     <= w_l;
                r_e     <= w_e;
            end else if (w_fail || w_mul_done) begin
                r_res   <= w_mul_done ? w_mul_prod : '0;
                r_err   <= w_fail;
                r_oflow <= 1'b0;
                r_cout  <= 1'b0;
                r_g     <= 1'b0;
                r_l     <= 1'b0;
                r_e     <= 1'b0;
            end
        end
    end

    assign bus.res       = r_res;
    assign bus.res_valid = r_res_valid;
    assign bus.busy      = (r_state != IDLE);
    assign bus.err       = r_err;
    assign bus.oflow     = r_oflow;
    assign bus.cout      = r_cout;
    assign bus.g         = r_g;
    assign bus.l         = r_l;
    assign bus.e         = r_e;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe (WIDTH=8, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8)) bus ();

    alu_pipe #(
        .WIDTH   (8),
        .TIMEOUT (16),
        .MUL_LAT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus.mode      = m;
        bus.cmd       = c;
        bus.inp_valid = iv;
        bus.opa       = a;
        bus.opb       = b;
        bus.cin       = ci;
    endtask

    function automatic logic [31:0] flags();
        return 32'({bus.oflow, bus.cout, bus.g, bus.l, bus.e});
    endfunction

    // Single-cycle op: result, flags {oflow,cout,g,l,e}, err and strobe
    task automatic run_vec(input string name, input logic m, input logic [3:0] c,
                           input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic [31:0] exp_res,
                           input logic [31:0] exp_err, input logic [31:0] exp_flg);
        drive(m, c, iv, a, b, ci);
        tick();
        chk({name, ".res"},   32'(bus.res),       exp_res);
        chk({name, ".err"},   32'(bus.err),       exp_err);
        chk({name, ".flags"}, flags(),            exp_flg);
        chk({name, ".valid"}, 32'(bus.res_valid), 1);
    endtask

    initial begin
        int n;
        rst    = 1'b0;
        bus.ce = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("rst.res",   32'(bus.res),       0);
        chk("rst.valid", 32'(bus.res_valid), 0);
        chk("rst.busy",  32'(bus.busy),      0);
        chk("rst.err",   32'(bus.err),       0);

        rst = 1'b1;
        run_vec("add_3_4", 1'b1, 4'd0, 2'b11, 8'h03, 8'h04, 1'b0, 'h007, 0, 'b00000);

        // Reset while an operation is outstanding
`ifdef ALU_MUL_EN
        drive(1'b1, 4'd9, 2'b11, 8'h0F, 8'h0F, 1'b0);
`else
        drive(1'b1, 4'd0, 2'b01, 8'h10, 8'h00, 1'b0);
`endif
        tick();
        chk("midrst.busy_before", 32'(bus.busy), 1);
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst.busy",  32'(bus.busy),      0);
        chk("midrst.valid", 32'(bus.res_valid), 0);
        chk("midrst.res",   32'(bus.res),       0);
        rst = 1'b1;

        tick();
        chk("iv00.valid", 32'(bus.res_valid), 1);
        chk("iv00.err",   32'(bus.err),       1);
        chk("iv00.res",   32'(bus.res),       0);

        // Split ADD: opa first, opb three cycles later; bus cmd/opa changes ignored
        drive(1'b1, 4'd0, 2'b01, 8'hF0, 8'h00, 1'b0);
        tick();
        chk("split.busy",  32'(bus.busy),      1);
        chk("split.valid0", 32'(bus.res_valid), 0);
        drive(1'b0, 4'd5, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        drive(1'b0, 4'd5, 2'b10, 8'h00, 8'h20, 1'b0);
        tick();
        chk("split.res",   32'(bus.res),       'h110);
        chk("split.cout",  32'(bus.cout),      1);
        chk("split.valid", 32'(bus.res_valid), 1);
        chk("split.busy1", 32'(bus.busy),      0);

        // Timeout on a missing opb
        drive(1'b0, 4'd0, 2'b01, 8'hFF, 8'h00, 1'b0);
        tick();
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        n = 0;
        repeat (15) begin
            tick();
            if (bus.res_valid !== 1'b0) n++;
        end
        chk("tmo.quiet", 32'(n), 0);
        tick();
        chk("tmo.valid", 32'(bus.res_valid), 1);
        chk("tmo.err",   32'(bus.err),       1);
        chk("tmo.res",   32'(bus.res),       0);
        chk("tmo.busy",  32'(bus.busy),      0);

        // ce=0 in WAIT freezes the timeout counter; then ROL with out-of-range opb
        drive(1'b0, 4'd12, 2'b01, 8'h81, 8'h00, 1'b0);
        tick();
        bus.ce = 1'b0;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        n = 0;
        repeat (20) begin
            tick();
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) n++;
        end
        chk("cefrz.held", 32'(n), 0);
        bus.ce = 1'b1;
        drive(1'b0, 4'd0, 2'b10, 8'h00, 8'h09, 1'b0);
        tick();
        chk("rol9.res",   32'(bus.res),       'h03);
        chk("rol9.err",   32'(bus.err),       1);
        chk("rol9.valid", 32'(bus.res_valid), 1);

        run_vec("cmp_5_9",  1'b1, 4'd8,  2'b11, 8'h05, 8'h09, 1'b0, 'h000, 0, 'b00010);
        run_vec("add_1_1",  1'b1, 4'd0,  2'b11, 8'h01, 8'h01, 1'b0, 'h002, 0, 'b00000);
        run_vec("cmp_7_7",  1'b1, 4'd8,  2'b11, 8'h07, 8'h07, 1'b0, 'h000, 0, 'b00001);
        run_vec("cmp_9_5",  1'b1, 4'd8,  2'b11, 8'h09, 8'h05, 1'b0, 'h000, 0, 'b00100);
        run_vec("sub_3_5",  1'b1, 4'd1,  2'b11, 8'h03, 8'h05, 1'b0, 'h1FE, 0, 'b10000);
        run_vec("subc",     1'b1, 4'd3,  2'b11, 8'h10, 8'h05, 1'b1, 'h00A, 0, 'b00000);
        run_vec("addc",     1'b1, 4'd2,  2'b11, 8'hFF, 8'h00, 1'b1, 'h100, 0, 'b01000);
        run_vec("dec_a0",   1'b1, 4'd5,  2'b01, 8'h00, 8'h00, 1'b0, 'h1FF, 0, 'b10000);
        run_vec("inc_bff",  1'b1, 4'd6,  2'b10, 8'h00, 8'hFF, 1'b0, 'h100, 0, 'b01000);
        run_vec("dec_b",    1'b1, 4'd7,  2'b10, 8'h00, 8'h10, 1'b0, 'h00F, 0, 'b00000);
        run_vec("nand",     1'b0, 4'd1,  2'b11, 8'hF0, 8'h3C, 1'b0, 'h0CF, 0, 'b00000);
        run_vec("nor",      1'b0, 4'd3,  2'b11, 8'h0F, 8'hF0, 1'b0, 'h000, 0, 'b00000);
        run_vec("xnor",     1'b0, 4'd5,  2'b11, 8'hAA, 8'h0F, 1'b0, 'h05A, 0, 'b00000);
        run_vec("not_b",    1'b0, 4'd7,  2'b10, 8'h00, 8'h0F, 1'b0, 'h0F0, 0, 'b00000);
        run_vec("shl1_a",   1'b0, 4'd9,  2'b01, 8'h81, 8'h00, 1'b0, 'h002, 0, 'b00000);
        run_vec("shr1_b",   1'b0, 4'd10, 2'b10, 8'h00, 8'h81, 1'b0, 'h040, 0, 'b00000);
        run_vec("rol3",     1'b0, 4'd12, 2'b11, 8'h81, 8'h03, 1'b0, 'h00C, 0, 'b00000);
        run_vec("ror1",     1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0, 'h0C0, 0, 'b00000);
        run_vec("bad_l14",  1'b0, 4'd14, 2'b11, 8'h12, 8'h34, 1'b0, 'h000, 1, 'b00000);
        run_vec("bad_a11",  1'b1, 4'd11, 2'b11, 8'h12, 8'h34, 1'b0, 'h000, 1, 'b00000);

`ifdef ALU_MUL_EN
        drive(1'b1, 4'd9, 2'b11, 8'h0F, 8'h0F, 1'b0);
        tick();
        chk("mul.busy1",  32'(bus.busy),      1);
        chk("mul.valid1", 32'(bus.res_valid), 0);
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("mul.busy2", 32'(bus.busy), 1);
        tick();
        chk("mul.busy3",  32'(bus.busy),      1);
        chk("mul.valid3", 32'(bus.res_valid), 0);
        tick();
        chk("mul.res",   32'(bus.res),       'h100);
        chk("mul.valid", 32'(bus.res_valid), 1);
        chk("mul.busy",  32'(bus.busy),      0);
        chk("mul.err",   32'(bus.err),       0);
        drive(1'b1, 4'd10, 2'b11, 8'h80, 8'h03, 1'b0);
        repeat (3) tick();
        chk("mulshl.pending", 32'(bus.res_valid), 0);
        tick();
        chk("mulshl.res", 32'(bus.res), 'h300);
`else
        run_vec("mul_off",  1'b1, 4'd9,  2'b11, 8'h0F, 8'h0F, 1'b0, 'h000, 1, 'b00000);
        chk("mul_off.busy", 32'(bus.busy), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
